// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that shares one APB master port among NUM_REQ requesters.
// It grants one requester at a time, runs SETUP/ACCESS, and returns rdata plus a timeout flag.
module apb_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                        pclk,
    input  logic                        prst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          req_done,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_err,
    output logic                        m_psel,
    output logic                        m_penable,
    output logic [ADDR_W-1:0]           m_paddr,
    output logic                        m_pwrite,
    output logic [DATA_W-1:0]           m_pwdata,
    input  logic                        m_pready,
    input  logic [DATA_W-1:0]           m_prdata
);

    localparam int GW    = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [GW-1:0]    LAST_RST  = GW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } state_t;

    state_t              state_q;
    logic [GW-1:0]       grant_q;
    logic [GW-1:0]       last_grant_q;
    logic [CNT_W-1:0]    wait_cnt_q;
    logic                psel_q;
    logic                penable_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic [DATA_W-1:0]   wdata_q;

    logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
    end

    // Two-pass priority search: indices above last_grant first, then wrap to the low indices.
    logic          hi_found;
    logic          lo_found;
    logic [GW-1:0] hi_idx;
    logic [GW-1:0] lo_idx;
    logic          win_found;
    logic [GW-1:0] win_idx;

    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (GW'(i) > last_grant_q) begin
                    hi_found = 1'b1;
                    hi_idx   = GW'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = GW'(i);
                end
            end
        end
        win_found = hi_found | lo_found;
        win_idx   = hi_found ? hi_idx : lo_idx;
    end

    logic timed_out;
    logic xfer_end;
    logic done_vld;

    // pready wins over the timeout in the limit cycle; a reset cycle never reports completion.
    assign timed_out = TO_EN && (wait_cnt_q == CNT_LIMIT);
    assign xfer_end  = (state_q == S_ACCESS) && (m_pready || timed_out);
    assign done_vld  = xfer_end && !prst;

    always_comb begin
        req_done = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_done[i] = done_vld && (grant_q == GW'(i));
        end
    end

    assign rsp_rdata = done_vld ? m_prdata : '0;
    assign rsp_err   = done_vld && !m_pready;

    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_RST;
            wait_cnt_q   <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    if (win_found) begin
                        grant_q <= win_idx;
                        addr_q  <= addr_arr[win_idx];
                        write_q <= req_write[win_idx];
                        wdata_q <= wdata_arr[win_idx];
                        psel_q  <= 1'b1;
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    penable_q  <= 1'b1;
                    wait_cnt_q <= '0;
                    state_q    <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (xfer_end) begin
                        last_grant_q <= grant_q;
                        psel_q       <= 1'b0;
                        penable_q    <= 1'b0;
                        wait_cnt_q   <= '0;
                        state_q      <= S_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign m_psel    = psel_q;
    assign m_penable = penable_q;
    assign m_paddr   = addr_q;
    assign m_pwrite  = write_q;
    assign m_pwdata  = wdata_q;

endmodule
